untrusted_access_filter: RTL and testbench

// - Access-control stage directly upstream of the untrusted ROM/RAM windows.
// - Each request from the untrusted device is matched against the ROM and RAM windows.
// - Legal requests go downstream with a window select; illegal ones get a local error response.
// - Every violation is counted and the first one is logged for the security monitor.
// - One outstanding transaction; valid/ready on every channel.

---
 rtl/untrusted_access_filter.sv | 141 ++++++++++++++
 tb/tb_untrusted_access_filter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/untrusted_access_filter.sv
// Access-control filter in front of the untrusted ROM/RAM windows; one outstanding transaction; counts and logs violations.
// Latency: accept@T, dn_valid@T+1, rsp one cycle after dn_rvalid; error rsp@T+1. Valid/ready on all channels; payloads held while stalled.
// Optional macro UNTRUSTED_FILTER_ROM_WP_EN makes writes to the ROM window illegal.
module untrusted_access_filter #(
    parameter logic [31:0] RomBase = 32'h0000_0000,
    parameter logic [31:0] RomMask = 32'h0000_3fff,
    parameter logic [31:0] RamBase = 32'h5000_0000,
    parameter logic [31:0] RamMask = 32'h0001_ffff,
    parameter int          CntW    = 16,
    parameter logic [31:0] ErrData = 32'hffff_ffff
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [31:0]     req_addr_i,
    input  logic            req_we_i,
    input  logic [31:0]     req_wdata_i,
    output logic            dn_valid_o,
    input  logic            dn_ready_i,
    output logic            dn_sel_o,
    output logic [31:0]     dn_addr_o,
    output logic            dn_we_o,
    output logic [31:0]     dn_wdata_o,
    input  logic            dn_rvalid_i,
    input  logic [31:0]     dn_rdata_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic            rsp_err_o,
    output logic [31:0]     rsp_rdata_o,
    input  logic            viol_clr_i,
    output logic [CntW-1:0] viol_cnt_o,
    output logic [31:0]     viol_addr_o,
    output logic            irq_o
);

    typedef enum logic [2:0] {IDLE, FWD, WAIT, RSP, ERR} state_t;

    localparam logic [CntW-1:0] CntOne = {{(CntW-1){1'b0}}, 1'b1};
    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

    state_t state, state_nxt;

    logic rom_hit, ram_hit, aligned, legal, accept, viol;

    logic            sel_q;
    logic [31:0]     off_q;
    logic            we_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     vaddr_q;

    always_comb begin
        rom_hit = (req_addr_i & ~RomMask) == RomBase;
        ram_hit = (req_addr_i & ~RamMask) == RamBase;
        aligned = req_addr_i[1:0] == 2'b00;
`ifdef UNTRUSTED_FILTER_ROM_WP_EN
        legal   = aligned & (ram_hit | (rom_hit & ~req_we_i));
`else
        legal   = aligned & (ram_hit | rom_hit);
`endif
    end

    assign accept = (state == IDLE) & req_valid_i;
    assign viol   = accept & ~legal;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid_i) state_nxt = legal ? FWD : ERR;
            FWD:  if (dn_ready_i)  state_nxt = WAIT;
            WAIT: if (dn_rvalid_i) state_nxt = RSP;
            RSP:  if (rsp_ready_i) state_nxt = IDLE;
            ERR:  if (rsp_ready_i) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q   <= 1'b0;
            off_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                sel_q   <= ram_hit;
                off_q   <= ram_hit ? (req_addr_i & RamMask) : (req_addr_i & RomMask);
                we_q    <= req_we_i;
                wdata_q <= req_wdata_i;
            end
            // Responses arriving outside WAIT are stray and must not disturb the held data.
            if ((state == WAIT) && dn_rvalid_i) begin
                rdata_q <= we_q ? '0 : dn_rdata_i;
            end
        end
    end

    // A violation in the same cycle as a clear survives as the first entry of the new log.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            vaddr_q <= '0;
        end else if (viol) begin
            if (viol_clr_i) begin
                cnt_q   <= CntOne;
                vaddr_q <= req_addr_i;
            end else begin
                if (cnt_q != CntMax) cnt_q <= cnt_q + CntOne;
                if (cnt_q == '0)     vaddr_q <= req_addr_i;
            end
        end else if (viol_clr_i) begin
            cnt_q   <= '0;
            vaddr_q <= '0;
        end
    end

    assign req_ready_o = (state == IDLE) & ~rst_i;
    assign dn_valid_o  = (state == FWD);
    assign dn_sel_o    = sel_q;
    assign dn_addr_o   = off_q;
    assign dn_we_o     = we_q;
    assign dn_wdata_o  = wdata_q;
    assign rsp_valid_o = (state == RSP) | (state == ERR);
    assign rsp_err_o   = (state == ERR);
    assign rsp_rdata_o = (state == ERR) ? ErrData : rdata_q;
    assign viol_cnt_o  = cnt_q;
    assign viol_addr_o = vaddr_q;
    assign irq_o       = (cnt_q != '0);

endmodule

// File: tb/tb_untrusted_access_filter.sv
// Directed and randomized bench for untrusted_access_filter against a window/range reference model.
// A second instance with a 4-bit counter exercises saturation within a short run.
module tb_untrusted_access_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, dn_ready, dn_rvalid, rsp_ready, viol_clr;
    logic [31:0] req_addr, req_wdata, dn_rdata;

    logic        req_ready, dn_valid, dn_sel, dn_we, rsp_valid, rsp_err, irq;
    logic [31:0] dn_addr, dn_wdata, rsp_rdata, viol_addr;
    logic [15:0] viol_cnt;

    logic        s_req_ready, s_dn_valid, s_dn_sel, s_dn_we, s_rsp_valid, s_rsp_err, s_irq;
    logic [31:0] s_dn_addr, s_dn_wdata, s_rsp_rdata, s_viol_addr;
    logic [3:0]  s_viol_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    int          m_cnt = 0;
    logic [31:0] m_vaddr = 32'h0;

    always #5 clk = ~clk;

    untrusted_access_filter dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_we_i(req_we), .req_wdata_i(req_wdata),
        .dn_valid_o(dn_valid), .dn_ready_i(dn_ready), .dn_sel_o(dn_sel), .dn_addr_o(dn_addr),
        .dn_we_o(dn_we), .dn_wdata_o(dn_wdata), .dn_rvalid_i(dn_rvalid), .dn_rdata_i(dn_rdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata),
        .viol_clr_i(viol_clr), .viol_cnt_o(viol_cnt), .viol_addr_o(viol_addr), .irq_o(irq)
    );

    untrusted_access_filter #(.CntW(4)) dut_sat (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(s_req_ready), .req_addr_i(req_addr),
        .req_we_i(req_we), .req_wdata_i(req_wdata),
        .dn_valid_o(s_dn_valid), .dn_ready_i(dn_ready), .dn_sel_o(s_dn_sel), .dn_addr_o(s_dn_addr),
        .dn_we_o(s_dn_we), .dn_wdata_o(s_dn_wdata), .dn_rvalid_i(dn_rvalid), .dn_rdata_i(dn_rdata),
        .rsp_valid_o(s_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_err_o(s_rsp_err), .rsp_rdata_o(s_rsp_rdata),
        .viol_clr_i(viol_clr), .viol_cnt_o(s_viol_cnt), .viol_addr_o(s_viol_addr), .irq_o(s_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: ROM is [0x0, 0x3fff], RAM is [0x5000_0000, 0x5001_ffff], word aligned only.
    function automatic bit m_in_rom(input logic [31:0] a);
        return a <= 32'h0000_3fff;
    endfunction

    function automatic bit m_in_ram(input logic [31:0] a);
        return (a >= 32'h5000_0000) && (a <= 32'h5001_ffff);
    endfunction

    function automatic bit m_legal(input logic [31:0] a, input logic we);
        if (a % 4 != 0) return 1'b0;
`ifdef UNTRUSTED_FILTER_ROM_WP_EN
        if (m_in_rom(a) && we) return 1'b0;
`endif
        return m_in_rom(a) || m_in_ram(a);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] bnd [8] = '{32'h0, 32'h3ffc, 32'h4000, 32'h4fff_fffc,
                                 32'h5000_0000, 32'h5001_fffc, 32'h5002_0000, 32'h0fff_fffc};
        case ($urandom_range(0, 5))
            0: return 32'($urandom_range(0, 32'h3fff));
            1: return 32'h5000_0000 + 32'($urandom_range(0, 32'h1ffff));
            2: return bnd[$urandom_range(0, 7)];
            3: return $urandom;
            4: return 32'($urandom_range(0, 32'h3fff)) & ~32'h3;
            default: return (32'h5000_0000 + 32'($urandom_range(0, 32'h1ffff))) & ~32'h3;
        endcase
    endfunction

    task automatic check_log();
        chk("viol_cnt",  32'(viol_cnt), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
        chk("viol_addr", viol_addr, m_vaddr);
        chk("irq",       32'(irq), 32'(m_cnt != 0));
        chk("sat_cnt",   32'(s_viol_cnt), (m_cnt > 15) ? 32'd15 : 32'(m_cnt));
    endtask

    task automatic txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                       input logic [31:0] rd, input int dw, input int rw, input int sw,
                       input logic clr);
        bit          lg, first;
        logic        sel;
        logic [31:0] off, exp_rd;
        lg  = m_legal(a, we);
        sel = m_in_ram(a);
        off = sel ? a - 32'h5000_0000 : a;
        first = 1'b1;
        req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd; viol_clr = clr;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; viol_clr = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = ~we;
        if (!lg) begin
            if (clr) m_cnt = 1; else m_cnt++;
            if (m_cnt == 1) m_vaddr = a;
        end else if (clr) begin
            m_cnt = 0; m_vaddr = 32'h0;
        end
        if (lg) begin
            exp_rd = we ? 32'h0 : rd;
            for (int i = 0; i <= dw; i++) begin
                dn_ready  = (i == dw);
                dn_rvalid = (i < dw) ? 1'($urandom_range(0, 1)) : 1'b0;
                dn_rdata  = $urandom;
                @(negedge clk);
                if (first) begin check_log(); first = 1'b0; end
                chk("dn_valid", 32'(dn_valid), 32'd1);
                chk("dn_sel",   32'(dn_sel), 32'(sel));
                chk("dn_addr",  dn_addr, off);
                chk("dn_we",    32'(dn_we), 32'(we));
                chk("dn_wdata", dn_wdata, wd);
                chk("rsp_valid_fwd", 32'(rsp_valid), 32'd0);
                chk("req_ready_busy", 32'(req_ready), 32'd0);
                @(posedge clk); #1;
            end
            dn_ready = 1'b0;
            for (int i = 0; i <= rw; i++) begin
                dn_rvalid = (i == rw);
                dn_rdata  = (i == rw) ? rd : $urandom;
                @(negedge clk);
                chk("dn_valid_wait", 32'(dn_valid), 32'd0);
                chk("rsp_valid_wait", 32'(rsp_valid), 32'd0);
                @(posedge clk); #1;
            end
            dn_rvalid = 1'b0; dn_rdata = $urandom;
        end else begin
            exp_rd = 32'hffff_ffff;
        end
        for (int i = 0; i <= sw; i++) begin
            rsp_ready = (i == sw);
            @(negedge clk);
            if (first) begin check_log(); first = 1'b0; end
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_err",   32'(rsp_err), 32'(!lg));
            chk("rsp_rdata", rsp_rdata, exp_rd);
            chk("dn_valid_rsp", 32'(dn_valid), 32'd0);
            chk("req_ready_rsp", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("req_ready_back", 32'(req_ready), 32'd1);
        chk("rsp_valid_done", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_clr();
        viol_clr = 1'b1;
        @(posedge clk); #1;
        viol_clr = 1'b0;
        m_cnt = 0; m_vaddr = 32'h0;
        @(negedge clk);
        check_log();
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_dn_valid"},  32'(dn_valid), 32'd0);
        chk({tag, "_dn_sel"},    32'(dn_sel), 32'd0);
        chk({tag, "_dn_addr"},   dn_addr, 32'd0);
        chk({tag, "_dn_we"},     32'(dn_we), 32'd0);
        chk({tag, "_dn_wdata"},  dn_wdata, 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_viol_cnt"},  32'(viol_cnt), 32'd0);
        chk({tag, "_viol_addr"}, viol_addr, 32'd0);
        chk({tag, "_irq"},       32'(irq), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0; req_wdata = 32'h0;
        dn_ready = 1'b0; dn_rvalid = 1'b0; dn_rdata = 32'h0; rsp_ready = 1'b0; viol_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("req_ready_after_reset", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        txn(32'h0000_0100, 1'b0, 32'h0, 32'h0000_1234, 0, 1, 0, 1'b0);
        txn(32'h5001_fffc, 1'b1, 32'hcafe_f00d, 32'h0, 0, 0, 0, 1'b0);
        txn(32'h5002_0000, 1'b1, 32'h1111_2222, 32'h0, 0, 0, 0, 1'b0);
        pulse_clr();
        txn(32'h0000_0102, 1'b0, 32'h0, 32'h0, 0, 0, 1, 1'b0);
        txn(32'h9000_0000, 1'b0, 32'h0, 32'h0, 0, 0, 0, 1'b0);
        txn(32'h5000_0040, 1'b0, 32'h0, 32'hdead_beef, 5, 2, 5, 1'b0);
        txn(32'h6000_0000, 1'b0, 32'h0, 32'h0, 0, 0, 0, 1'b1);
        txn(32'h0000_0010, 1'b1, 32'h0bad_c0de, 32'h0, 1, 0, 0, 1'b0);

        for (int n = 0; n < 250; n++) begin
            txn(rand_addr(), 1'($urandom_range(0, 1)), $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 15) == 0));
        end

        pulse_clr();
        for (int n = 0; n < 20; n++) begin
            txn(32'h9000_0000 + 32'(n * 4), 1'b0, 32'h0, 32'h0, 0, 0, 0, 1'b0);
        end

        req_valid = 1'b1; req_addr = 32'h5000_0100; req_we = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("fwd_before_reset", 32'(dn_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_all_zero("midreset");
        chk("midreset_sat_cnt", 32'(s_viol_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_cnt = 0; m_vaddr = 32'h0;
        @(negedge clk);
        chk("req_ready_after_midreset", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        txn(32'h0000_0200, 1'b0, 32'h0, 32'h0000_5678, 0, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
